buffer_w_reader: RTL

- Read-side sequencer for the weight buffer.
- Accepts a read command (base row, row count, repeat count) from the controller.
- Issues row read addresses to the weight buffer's mm read port. That port has a fixed latency and no backpressure.
- Captures the returned rows in a small credit-guarded FIFO and presents them to the matrix-multiply engine as a valid/ready stream with a last marker.

---
 rtl/buffer_w_reader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/buffer_w_reader.sv
// buffer_w_reader
//   Read-side sequencer for the weight buffer. Takes a (base, len, repeat)
//   read command, walks base..base+len-1 (mod 2^BUFFER_ADDR_WIDTH) repeat
//   times on the weight buffer's fixed-latency mm read port, and streams the
//   returned rows to the matrix-multiply engine through a credit-guarded FIFO.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only when idle)
//   cmd_base_addr            first row
//   cmd_len                  rows per pass (0 = empty command)
//   cmd_repeat               passes (0 treated as 1)
//   mm_read_addr_valid/addr  row read request to weight buffer
//   mm_read_data_valid/data  row return from weight buffer (no backpressure)
//   out_valid/ready/data     row stream to consumer
//   out_last                 final row of final pass
//   busy                     command in progress
//   done                     one-cycle pulse at command completion
//   err                      sticky error flag (optional)
//
// Build option
//   BUFFER_W_READER_ERR_EN   when defined, err latches on an unexpected
//                            return (nothing in flight) or a FIFO overflow;
//                            otherwise err is tied low.

module buffer_w_reader #(
  parameter int unsigned BUFFER_ADDR_WIDTH = 13,
  parameter int unsigned BUFFER_DATA_WIDTH = 8192,
  parameter int unsigned READ_LATENCY      = 4,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned LEN_WIDTH         = 13,
  parameter int unsigned REPEAT_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  input  logic [REPEAT_WIDTH-1:0]      cmd_repeat,
  output logic                         mm_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] mm_read_addr,
  input  logic                         mm_read_data_valid,
  input  logic [BUFFER_DATA_WIDTH-1:0] mm_read_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUFFER_DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = LEN_WIDTH + REPEAT_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || READ_LATENCY == 0) begin : g_bad_cfg
    $error("buffer_w_reader: FIFO_DEPTH must be a power of 2 >= 2 and READ_LATENCY >= 1");
  end

  logic [1:0]                   state;
  logic [BUFFER_ADDR_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]         len;
  logic [LEN_WIDTH-1:0]         row_idx;
  logic [REPEAT_WIDTH-1:0]      rep;
  logic [REPEAT_WIDTH-1:0]      pass_idx;
  logic [TW-1:0]                total;
  logic [TW-1:0]                beat_cnt;
  logic [CW-1:0]                inflight;
  logic [CW-1:0]                count;
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [BUFFER_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                         done_q;

  logic                         credit;
  logic                         issue;
  logic                         ret;
  logic                         full;
  logic                         push;
  logic                         pop;
  logic                         last_row;
  logic                         last_pass;
  logic [REPEAT_WIDTH-1:0]      rep_eff;

  // Credit counts rows already in the FIFO plus rows still in the read
  // pipeline, both registered, so a same-cycle pop frees nothing until the
  // following cycle and the FIFO can never be overrun by returns.
  assign credit    = ({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);
  assign issue     = (state == S_ISSUE) && credit;
  assign ret       = mm_read_data_valid && (inflight != '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push      = ret && !full;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign last_row  = (row_idx == len - 1'b1);
  assign last_pass = (pass_idx == rep - 1'b1);
  assign rep_eff   = (cmd_repeat == '0) ? REPEAT_WIDTH'(1) : cmd_repeat;

  assign cmd_ready          = (state == S_IDLE);
  assign busy               = (state != S_IDLE);
  assign done               = done_q;
  assign mm_read_addr_valid = issue;
  assign mm_read_addr       = issue ? (base + BUFFER_ADDR_WIDTH'(row_idx)) : '0;
  assign out_data           = out_valid ? mem[rd_ptr] : '0;
  assign out_last           = out_valid && (beat_cnt == total - 1'b1);

  // Command sequencing. done is held in DRAIN for its pulse cycle so the
  // next command is only accepted the cycle after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base     <= '0;
      len      <= '0;
      row_idx  <= '0;
      rep      <= '0;
      pass_idx <= '0;
      total    <= '0;
      beat_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            base     <= cmd_base_addr;
            len      <= cmd_len;
            rep      <= rep_eff;
            total    <= TW'(cmd_len) * TW'(rep_eff);
            row_idx  <= '0;
            pass_idx <= '0;
            beat_cnt <= '0;
            if (cmd_len == '0) begin
              state  <= S_DRAIN;
              done_q <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (issue) begin
            if (last_row) begin
              row_idx <= '0;
              if (last_pass) state <= S_DRAIN;
              else           pass_idx <= pass_idx + 1'b1;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (done_q)               state  <= S_IDLE;
          else if (pop && out_last) done_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case ({issue, ret})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mm_read_data;
  end

`ifdef BUFFER_W_READER_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((mm_read_data_valid && (inflight == '0)) || (ret && full)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
